// File: rtl/fetch_sequencer.sv
// Fetch/operand-load sequencer: fetches a 16-bit instruction as two bytes via PC,
// hands it to the consumer, and optionally loads a 32-bit big-endian operand via AR.
//
// state   | meaning
// IDLE    | no memory activity, waiting for Start
// FETCH_L | read low instruction byte at PC, PC++
// FETCH_H | read high instruction byte at PC, PC++
// WAIT    | IR valid, waiting for consumer handshake
// OPLOAD  | four byte reads at AR into DR (counter 0..3), AR++
// DONE    | one-cycle operand-complete pulse
module fetch_sequencer (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Halt,
    input  logic       InstrReady,
    input  logic       OpReq,
    output logic       InstrValid,
    output logic       OpDone,
    output logic       Busy,
    output logic       Mem_CS,
    output logic       Mem_WR,
    output logic       IR_LH,
    output logic       IR_Write,
    output logic       DR_E,
    output logic [1:0] ARF_OutDSel,
    output logic [1:0] ARF_FunSel,
    output logic [1:0] DR_FunSel,
    output logic [2:0] ARF_RegSel
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_WAIT    = 3'd3,
        S_OPLOAD  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next;
            // Counter only moves inside OPLOAD; it wraps 3->0 on the exit edge.
            if (r_state == S_WAIT && w_next == S_OPLOAD) begin
                r_cnt <= 2'd0;
            end else if (r_state == S_OPLOAD) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        InstrValid  = 1'b0;
        OpDone      = 1'b0;
        Busy        = 1'b1;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        DR_E        = 1'b0;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        DR_FunSel   = 2'b00;
        ARF_RegSel  = 3'b111;

        case (r_state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    w_next = S_FETCH_L;
                end
            end
            S_FETCH_L: begin
                Mem_CS     = 1'b0;
                IR_Write   = 1'b1;
                ARF_RegSel = 3'b011;
                ARF_FunSel = 2'b01;
                w_next     = S_FETCH_H;
            end
            S_FETCH_H: begin
                Mem_CS     = 1'b0;
                IR_Write   = 1'b1;
                IR_LH      = 1'b1;
                ARF_RegSel = 3'b011;
                ARF_FunSel = 2'b01;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                InstrValid = 1'b1;
                // An operand request takes priority over Halt at the handshake.
                if (InstrReady) begin
                    if (OpReq) begin
                        w_next = S_OPLOAD;
                    end else if (Halt) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_FETCH_L;
                    end
                end
            end
            S_OPLOAD: begin
                Mem_CS      = 1'b0;
                ARF_OutDSel = 2'b01;
                ARF_RegSel  = 3'b101;
                ARF_FunSel  = 2'b01;
                DR_E        = 1'b1;
                DR_FunSel   = 2'b10;
                if (r_cnt == 2'd3) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                OpDone = 1'b1;
                w_next = Halt ? S_IDLE : S_FETCH_L;
            end
            default: begin
                Busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte memory + PC/AR/SP/IR/DR environment, a
// count-based reference model checked every cycle, and directed literal checks.
module tb_fetch_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Halt = 1'b0;
    logic       InstrReady = 1'b0;
    logic       OpReq = 1'b0;
    logic       InstrValid, OpDone, Busy, Mem_CS, Mem_WR, IR_LH, IR_Write, DR_E;
    logic [1:0] ARF_OutDSel, ARF_FunSel, DR_FunSel;
    logic [2:0] ARF_RegSel;

    int checks = 0;
    int failures = 0;

    fetch_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Halt(Halt),
        .InstrReady(InstrReady), .OpReq(OpReq), .InstrValid(InstrValid),
        .OpDone(OpDone), .Busy(Busy), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR),
        .IR_LH(IR_LH), .IR_Write(IR_Write), .DR_E(DR_E),
        .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
        .DR_FunSel(DR_FunSel), .ARF_RegSel(ARF_RegSel)
    );

    always #5 Clock = ~Clock;

    // Environment: memory and register file driven by the control outputs.
    logic [7:0]  mem [0:1023];
    logic [15:0] pc, ar, sp, ir, addr;
    logic [31:0] dr;
    logic [7:0]  rd;
    logic        dp_init = 1'b1;

    always_comb begin
        addr = sp;
        if (ARF_OutDSel == 2'b00) addr = pc;
        else if (ARF_OutDSel == 2'b01) addr = ar;
    end
    assign rd = mem[addr[9:0]];

    always @(posedge Clock) begin
        if (dp_init) begin
            pc <= 16'h0010; ar <= 16'h0100; sp <= 16'h0000;
            ir <= 16'h0000; dr <= 32'h0;
        end else begin
            if (!Mem_CS && !Mem_WR) begin
                if (IR_Write) begin
                    if (IR_LH) ir[15:8] <= rd;
                    else       ir[7:0]  <= rd;
                end
                if (DR_E && DR_FunSel == 2'b10) dr <= {dr[23:0], rd};
            end
            if (ARF_FunSel == 2'b01) begin
                if (!ARF_RegSel[2]) pc <= pc + 16'd1;
                if (!ARF_RegSel[1]) ar <= ar + 16'd1;
                if (!ARF_RegSel[0]) sp <= sp + 16'd1;
            end
        end
    end

    // Reference model: bytes left to fetch, pending handshake, operand bytes left, done pulse.
    int m_fetch = 0;
    int m_op = 0;
    bit m_wait = 0;
    bit m_done = 0;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            m_fetch = 0; m_op = 0; m_wait = 0; m_done = 0;
        end else if (m_fetch > 0) begin
            m_fetch = m_fetch - 1;
            if (m_fetch == 0) m_wait = 1;
        end else if (m_wait) begin
            if (InstrReady) begin
                m_wait = 0;
                if (OpReq) m_op = 4;
                else if (!Halt) m_fetch = 2;
            end
        end else if (m_op > 0) begin
            m_op = m_op - 1;
            if (m_op == 0) m_done = 1;
        end else if (m_done) begin
            m_done = 0;
            if (!Halt) m_fetch = 2;
        end else if (Start) begin
            m_fetch = 2;
        end
    end

    function automatic logic [16:0] exp_vec();
        logic iv, od, bsy, cs, lh, irw, dre;
        logic [1:0] outd, fun, drf;
        logic [2:0] rs;
        iv = m_wait; od = m_done;
        bsy = (m_fetch != 0) || m_wait || (m_op != 0) || m_done;
        cs = 1'b1; lh = 1'b0; irw = 1'b0; dre = 1'b0;
        outd = 2'b00; fun = 2'b00; drf = 2'b00; rs = 3'b111;
        if (m_fetch > 0) begin
            cs = 1'b0; irw = 1'b1; lh = (m_fetch == 1); rs = 3'b011; fun = 2'b01;
        end
        if (m_op > 0) begin
            cs = 1'b0; outd = 2'b01; rs = 3'b101; fun = 2'b01; dre = 1'b1; drf = 2'b10;
        end
        return {iv, od, bsy, cs, 1'b0, lh, irw, dre, outd, fun, drf, rs};
    endfunction

    logic [16:0] dut_vec;
    assign dut_vec = {InstrValid, OpDone, Busy, Mem_CS, Mem_WR, IR_LH, IR_Write, DR_E,
                      ARF_OutDSel, ARF_FunSel, DR_FunSel, ARF_RegSel};

    bit cmp_en = 0;
    always @(negedge Clock) begin
        if (cmp_en) begin
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t got=%b want=%b", $time, dut_vec, exp_vec());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[16'h10] = 8'hA5; mem[16'h11] = 8'h5A;
        mem[16'h12] = 8'h34; mem[16'h13] = 8'h12;
        mem[16'h100] = 8'h11; mem[16'h101] = 8'h22; mem[16'h102] = 8'h33; mem[16'h103] = 8'h44;
        mem[16'h104] = 8'hDE; mem[16'h105] = 8'hAD; mem[16'h106] = 8'hBE; mem[16'h107] = 8'hEF;

        repeat (3) tick();
        cmp_en = 1;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_cs", 32'(Mem_CS), 32'd1);
        chk("reset_regsel", 32'(ARF_RegSel), 32'h7);
        dp_init = 0;
        Reset = 1;
        tick(); tick();
        chk("idle_no_start", 32'(Busy), 32'd0);

        // Fetch; Start held into FETCH_H must be ignored.
        Start = 1;
        tick();
        chk("fetch_l_lh", 32'(IR_LH), 32'd0);
        chk("fetch_l_regsel", 32'(ARF_RegSel), 32'h3);
        chk("fetch_l_cs", 32'(Mem_CS), 32'd0);
        tick();
        Start = 0;
        chk("fetch_h_lh", 32'(IR_LH), 32'd1);
        tick();
        chk("fetch_valid", 32'(InstrValid), 32'd1);
        chk("fetch_pc", 32'(pc), 32'h12);
        chk("fetch_ir", 32'(ir), 32'h5AA5);

        // Stall with Halt/OpReq high but no handshake.
        InstrReady = 0; Halt = 1; OpReq = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", 32'(InstrValid), 32'd1);
            chk("stall_cs", 32'(Mem_CS), 32'd1);
        end
        chk("stall_pc", 32'(pc), 32'h12);

        // Operand load; OpReq wins over Halt.
        InstrReady = 1;
        tick();
        InstrReady = 0; OpReq = 0; Halt = 0;
        chk("opload_dre", 32'(DR_E), 32'd1);
        repeat (3) tick();
        chk("opload_last_done", 32'(OpDone), 32'd0);
        tick();
        chk("op_done", 32'(OpDone), 32'd1);
        chk("op_dr", dr, 32'h11223344);
        chk("op_ar", 32'(ar), 32'h104);
        tick(); tick(); tick();
        chk("refetch_ir", 32'(ir), 32'h1234);
        chk("refetch_pc", 32'(pc), 32'h14);

        // Halt at handshake.
        Halt = 1; InstrReady = 1;
        tick();
        Halt = 0; InstrReady = 0;
        chk("halt_busy", 32'(Busy), 32'd0);
        chk("halt_valid", 32'(InstrValid), 32'd0);
        repeat (5) tick();
        chk("halt_pc", 32'(pc), 32'h14);

        // Start with Halt starts a fetch; DONE with Halt returns to IDLE.
        Start = 1; Halt = 1;
        tick();
        Start = 0; Halt = 0;
        chk("start_halt_busy", 32'(Busy), 32'd1);
        tick(); tick();
        OpReq = 1; InstrReady = 1; Halt = 1;
        tick();
        OpReq = 0; InstrReady = 0;
        repeat (4) tick();
        chk("op2_done", 32'(OpDone), 32'd1);
        chk("op2_dr", dr, 32'hDEADBEEF);
        chk("op2_ar", 32'(ar), 32'h108);
        tick();
        Halt = 0;
        chk("done_halt_busy", 32'(Busy), 32'd0);

        // Reset during OPLOAD counter 2.
        Start = 1;
        tick();
        Start = 0;
        tick(); tick();
        OpReq = 1; InstrReady = 1;
        tick();
        OpReq = 0; InstrReady = 0;
        tick(); tick();
        Reset = 0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_cs", 32'(Mem_CS), 32'd1);
        chk("rst_dre", 32'(DR_E), 32'd0);
        chk("rst_regsel", 32'(ARF_RegSel), 32'h7);
        tick();
        Reset = 1;
        repeat (6) tick();
        chk("post_rst_busy", 32'(Busy), 32'd0);
        chk("post_rst_ar", 32'(ar), 32'h10A);
        chk("post_rst_pc", 32'(pc), 32'h18);
        Start = 1;
        tick();
        Start = 0;
        chk("restart_busy", 32'(Busy), 32'd1);
        tick(); tick();
        chk("restart_valid", 32'(InstrValid), 32'd1);
        chk("sp_untouched", 32'(sp), 32'h0);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1: sole clock; all state changes on rising edge.
REQ-002 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port Start, input, 1: begin fetching when idle.
REQ-004 SHALL have port Halt, input, 1: return to idle at the next instruction boundary.
REQ-005 SHALL have port InstrReady, input, 1: consumer accepts the fetched instruction.
REQ-006 SHALL have port OpReq, input, 1: consumer requests a 32-bit operand load from AR; sampled with InstrReady.
REQ-007 SHALL have port InstrValid, output, 1: the 16-bit IR holds a complete instruction.
REQ-008 SHALL have port OpDone, output, 1: one-cycle pulse; DR holds the 32-bit operand.
REQ-009 SHALL have port Busy, output, 1: state is not IDLE.
REQ-010 SHALL have ports Mem_CS (active-low), Mem_WR (0 = read), IR_LH, IR_Write, DR_E (each output, 1) and ARF_OutDSel, ARF_FunSel, DR_FunSel (each output, 2).
REQ-011 SHALL have port ARF_RegSel, output, 3: active-low select; bit2 = PC, bit1 = AR, bit0 = SP.

Function
REQ-012 SHALL be a Moore FSM with states IDLE, FETCH_L, FETCH_H, WAIT, OPLOAD and DONE; all outputs decode from the state register and the 2-bit byte counter only.
REQ-013 SHALL drive inactive outputs in every state unless stated otherwise: Mem_CS=1, Mem_WR=0, IR_Write=0, IR_LH=0, ARF_RegSel=3'b111, ARF_FunSel=2'b00, ARF_OutDSel=2'b00, DR_E=0, DR_FunSel=2'b00, InstrValid=0, OpDone=0.
REQ-014 SHALL move IDLE -> FETCH_L on a rising edge with Start=1, and otherwise remain in IDLE.
REQ-015 SHALL, in FETCH_L (exactly 1 cycle): Mem_CS=0, ARF_OutDSel=2'b00 (PC), IR_Write=1, IR_LH=0, ARF_RegSel=3'b011, ARF_FunSel=2'b01 (PC increment); next state FETCH_H.
REQ-016 SHALL, in FETCH_H (exactly 1 cycle): same as FETCH_L but IR_LH=1; next state WAIT.
REQ-017 SHALL, in WAIT: InstrValid=1; hold until InstrReady=1, then go to OPLOAD if OpReq=1, else IDLE if Halt=1, else FETCH_L.
REQ-018 SHALL ignore OpReq and Halt while InstrReady=0; InstrValid stays high until the handshake completes.
REQ-019 SHALL, in OPLOAD (exactly 4 cycles, counter 0..3): Mem_CS=0, ARF_OutDSel=2'b01 (AR), ARF_RegSel=3'b101, ARF_FunSel=2'b01 (AR increment), DR_E=1, DR_FunSel=2'b10 (shift left 8 and load the byte into DR[7:0]); the first byte ends in DR[31:24].
REQ-020 SHALL clear the byte counter on OPLOAD entry and wrap it 3 -> 0 on exit; the counter SHALL NOT change outside OPLOAD.
REQ-021 SHALL, in DONE (1 cycle): OpDone=1; next state IDLE if Halt=1, else FETCH_L.
REQ-022 SHALL give a fetch latency of 3 cycles from the Start edge to InstrValid=1, and 5 cycles from the OpReq handshake edge to OpDone=1.
REQ-023 SHALL ignore Start outside IDLE; Start=1 together with Halt=1 in IDLE starts a fetch.
REQ-024 SHALL never assert Mem_WR=1, and SHALL never assert IR_Write and DR_E in the same cycle.

Reset
REQ-025 SHALL, on Reset=0 in any state, immediately (without a clock) enter IDLE, clear the counter and drive the REQ-013 outputs; Busy=0.
REQ-026 SHALL, on a reset during FETCH or OPLOAD, abandon the partial operation; no completion pulse follows deassertion.
REQ-027 SHALL leave IDLE no earlier than the first rising edge after Reset=1 with Start=1.

Verification
REQ-028 SHALL cover fetch: Start pulse -> FETCH_L (IR_LH=0, ARF_RegSel=3'b011), then FETCH_H (IR_LH=1), then InstrValid=1 in cycle 3; PC incremented twice.
REQ-029 SHALL cover stall: InstrReady held 0 for 10 cycles in WAIT -> InstrValid stays 1, Mem_CS stays 1, PC unchanged.
REQ-030 SHALL cover operand load: memory bytes 0x11,0x22,0x33,0x44 at AR..AR+3 with OpReq=1 at handshake -> 4 OPLOAD cycles, OpDone pulse, DR=0x11223344, AR advanced by 4.
REQ-031 SHALL cover halt: Halt=1 at the WAIT handshake with OpReq=0 -> IDLE next cycle, Busy=0, no further memory access.
REQ-032 SHALL cover reset: Reset=0 asserted in OPLOAD counter 2 -> outputs inactive before the next edge; after Reset=1 the block remains in IDLE until Start.
